// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package multdiv_pkg;

   localparam int WIDTH_DEF = 32;
   localparam logic [WIDTH_DEF-1:0] INT_MIN = 32'h80000000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [WIDTH_DEF-1:0] abs_val(input logic [WIDTH_DEF-1:0] v);
      return v[WIDTH_DEF-1] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [WIDTH_DEF-1:0] apply_sign(input logic [WIDTH_DEF-1:0] mag,
                                                        input logic neg);
      return neg ? (~mag + 32'd1) : mag;
   endfunction

   // Signed overflow of a 64-bit product: bits [63:31] must all match the sign.
   function automatic logic sign_ovf(input logic [WIDTH_DEF:0] hi);
      return !((&hi) || !(|hi));
   endfunction

endpackage

// File: rtl/multdiv_if.sv
// Start/operand/result handshake between decode, the mult/div unit and writeback.
interface multdiv_if #(parameter int WIDTH = 32);
   logic             ctrl_mult;
   logic             ctrl_div;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_mult, ctrl_div, data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_mult, ctrl_div, data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter for the Booth and restoring-division loops.
module multdiv_counter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [CNT_W-1:0] count_r;

   // Count enabled iterations, saturating once WIDTH have been taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (enable && (count_r != CNT_W'(WIDTH))) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // High during the iteration whose edge brings the count to WIDTH.
   assign done = enable && (count_r == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multi-cycle multiplier (radix-2 Booth) and restoring divider
// with a one-cycle result-ready pulse for the execute stage.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic      clock,
   input  logic      reset_n,
   multdiv_if.slave  bus
);

   state_t             state_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [2*WIDTH:0]   prod_r;
   logic [WIDTH-1:0]   dvsr_r;
   logic [WIDTH-1:0]   rem_r;
   logic [WIDTH-1:0]   quo_r;
   logic               neg_r;
   logic [WIDTH-1:0]   res_r;
   logic               exc_r;
   logic [WIDTH-1:0]   data_result_r;
   logic               data_exception_r;
   logic               rdy_r;
   logic               busy_r;

   logic               start_mult_s;
   logic               start_div_s;
   logic               cnt_done_s;
   logic [WIDTH:0]     booth_hi_s;
   logic [WIDTH:0]     mcand_ext_s;
   logic [WIDTH:0]     booth_sum_s;
   logic [2*WIDTH:0]   prod_next_s;
   logic [WIDTH:0]     shift_s;
   logic [WIDTH:0]     trial_s;
   logic [WIDTH-1:0]   rem_next_s;
   logic [WIDTH-1:0]   quo_next_s;

   assign start_mult_s = bus.ctrl_mult & ~bus.ctrl_div;
   assign start_div_s  = bus.ctrl_div & ~bus.ctrl_mult;

   multdiv_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state_r == IDLE),
      .enable  ((state_r == MULT) || (state_r == DIV)),
      .done    (cnt_done_s)
   );

   // Booth step: 33-bit add/sub on the sign-extended upper half, then arithmetic shift.
   always_comb begin
      booth_hi_s  = {prod_r[2*WIDTH], prod_r[2*WIDTH:WIDTH+1]};
      mcand_ext_s = {mcand_r[WIDTH-1], mcand_r};
      case (prod_r[1:0])
         2'b01:   booth_sum_s = booth_hi_s + mcand_ext_s;
         2'b10:   booth_sum_s = booth_hi_s - mcand_ext_s;
         default: booth_sum_s = booth_hi_s;
      endcase
      prod_next_s = {booth_sum_s, prod_r[WIDTH:1]};
   end

   // Restoring division step on magnitudes; quotient bits shift in behind the dividend.
   always_comb begin
      shift_s = {rem_r, quo_r[WIDTH-1]};
      trial_s = shift_s - {1'b0, dvsr_r};
      if (!trial_s[WIDTH]) begin
         rem_next_s = trial_s[WIDTH-1:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
      end else begin
         rem_next_s = shift_s[WIDTH-1:0];
         quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM and datapath registers; outputs update together with the ready pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r          <= IDLE;
         mcand_r          <= {WIDTH{1'b0}};
         prod_r           <= {(2*WIDTH+1){1'b0}};
         dvsr_r           <= {WIDTH{1'b0}};
         rem_r            <= {WIDTH{1'b0}};
         quo_r            <= {WIDTH{1'b0}};
         neg_r            <= 1'b0;
         res_r            <= {WIDTH{1'b0}};
         exc_r            <= 1'b0;
         data_result_r    <= {WIDTH{1'b0}};
         data_exception_r <= 1'b0;
         rdy_r            <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               rdy_r <= 1'b0;
               if (start_mult_s) begin
                  mcand_r <= bus.data_operandA;
                  prod_r  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
                  busy_r  <= 1'b1;
                  state_r <= MULT;
               end else if (start_div_s) begin
                  busy_r <= 1'b1;
                  if (bus.data_operandB == {WIDTH{1'b0}}) begin
                     res_r   <= {WIDTH{1'b0}};
                     exc_r   <= 1'b1;
                     state_r <= DONE;
                  end else if ((bus.data_operandA == INT_MIN) &&
                               (bus.data_operandB == {WIDTH{1'b1}})) begin
                     res_r   <= INT_MIN;
                     exc_r   <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     rem_r   <= {WIDTH{1'b0}};
                     quo_r   <= abs_val(bus.data_operandA);
                     dvsr_r  <= abs_val(bus.data_operandB);
                     neg_r   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                     state_r <= DIV;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            MULT: begin
               prod_r <= prod_next_s;
               if (cnt_done_s) begin
                  res_r   <= prod_next_s[WIDTH:1];
                  exc_r   <= sign_ovf(prod_next_s[2*WIDTH:WIDTH]);
                  state_r <= DONE;
               end else begin
                  state_r <= MULT;
               end
            end
            DIV: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s;
               if (cnt_done_s) begin
                  state_r <= FIX;
               end else begin
                  state_r <= DIV;
               end
            end
            FIX: begin
               res_r   <= apply_sign(quo_r, neg_r);
               exc_r   <= 1'b0;
               state_r <= DONE;
            end
            DONE: begin
               data_result_r    <= res_r;
               data_exception_r <= exc_r;
               rdy_r            <= 1'b1;
               busy_r           <= 1'b0;
               state_r          <= IDLE;
            end
            default: begin
               rdy_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_result    = data_result_r;
   assign bus.data_exception = data_exception_r;
   assign bus.data_resultRDY = rdy_r;
   assign bus.busy           = busy_r;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   multdiv_if #(.WIDTH(32)) bus ();

   multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   // Reference: exact 64-bit signed product; overflow when it does not fit 32 bits.
   function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
   endfunction

   // Reference: truncating signed division; exception on zero divisor or unrepresentable quotient.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
      longint q;
      if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = q[31:0];
         e = (q != longint'($signed(q[31:0])));
      end
   endfunction

   task automatic run_op(input logic do_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc, output int lat,
                         output logic busy_ok, output logic pulse_ok);
      @(negedge clk);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_mult = !do_div;
      bus.ctrl_div  = do_div;
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat = -1;
      busy_ok = bus.busy;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) begin
            lat = k;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
      res = bus.data_result;
      exc = bus.data_exception;
      if (bus.busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      pulse_ok = !bus.data_resultRDY && (bus.data_result === res) && (bus.data_exception === exc);
   endtask

   task automatic test_reset();
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      bus.data_operandA = 32'd0;
      bus.data_operandB = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs got res=%h exc=%b rdy=%b busy=%b want all 0",
                  bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.data_resultRDY, bus.busy} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_idle got rdy=%b busy=%b want 0 0", bus.data_resultRDY, bus.busy);
      end
   endtask

   task automatic test_mult();
      logic [31:0] opa [5] = '{32'd7, 32'h00010000, 32'h80000000, 32'h80000000, 32'h12345678};
      logic [31:0] opb [5] = '{32'hFFFFFFFD, 32'h00010000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
      logic [31:0] a, b, res, exp_res;
      logic exc, exp_exc, busy_ok, pulse_ok;
      int lat;
      for (int i = 0; i < 15; i++) begin
         if (i < 5) begin
            a = opa[i];
            b = opb[i];
         end else if (i % 2 == 0) begin
            a = $urandom;
            b = $urandom;
         end else begin
            a = 32'($urandom_range(0, 4000)) - 32'd2000;
            b = 32'($urandom_range(0, 4000)) - 32'd2000;
         end
         ref_mult(a, b, exp_res, exp_exc);
         run_op(1'b0, a, b, res, exc, lat, busy_ok, pulse_ok);
         tests_run += 5;
         if (res !== exp_res) begin
            tests_failed++;
            $display("FAIL mult_result a=%h b=%h got %h want %h", a, b, res, exp_res);
         end
         if (exc !== exp_exc) begin
            tests_failed++;
            $display("FAIL mult_exception a=%h b=%h got %b want %b", a, b, exc, exp_exc);
         end
         if (lat !== 33) begin
            tests_failed++;
            $display("FAIL mult_latency a=%h b=%h got %0d want 33", a, b, lat);
         end
         if (busy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL mult_busy a=%h b=%h got %b want 1", a, b, busy_ok);
         end
         if (pulse_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL mult_rdy_pulse a=%h b=%h got %b want 1", a, b, pulse_ok);
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] opa [7] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'h80000000, 32'd0, 32'hFFFFFFFF};
      logic [31:0] opb [7] = '{32'd2, 32'hFFFFFFF6, 32'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD, 32'h80000000};
      logic [31:0] a, b, res, exp_res;
      logic exc, exp_exc, busy_ok, pulse_ok;
      int lat, exp_lat;
      for (int i = 0; i < 19; i++) begin
         if (i < 7) begin
            a = opa[i];
            b = opb[i];
         end else if (i == 12) begin
            a = $urandom;
            b = 32'd0;
         end else if (i % 2 == 0) begin
            a = $urandom;
            b = $urandom;
         end else begin
            a = $urandom;
            b = 32'($urandom_range(0, 200)) - 32'd100;
         end
         ref_div(a, b, exp_res, exp_exc);
         exp_lat = exp_exc ? 1 : 34;
         run_op(1'b1, a, b, res, exc, lat, busy_ok, pulse_ok);
         tests_run += 5;
         if (res !== exp_res) begin
            tests_failed++;
            $display("FAIL div_result a=%h b=%h got %h want %h", a, b, res, exp_res);
         end
         if (exc !== exp_exc) begin
            tests_failed++;
            $display("FAIL div_exception a=%h b=%h got %b want %b", a, b, exc, exp_exc);
         end
         if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL div_latency a=%h b=%h got %0d want %0d", a, b, lat, exp_lat);
         end
         if (busy_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_busy a=%h b=%h got %b want 1", a, b, busy_ok);
         end
         if (pulse_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL div_rdy_pulse a=%h b=%h got %b want 1", a, b, pulse_ok);
         end
      end
   endtask

   task automatic test_ignore();
      int pulses = 0;
      int first = -1;
      int busy_cycles = 0;
      @(negedge clk);
      bus.data_operandA = 32'hFFFFFFF9;
      bus.data_operandB = 32'd2;
      bus.ctrl_div = 1'b1;
      @(posedge clk);
      #1;
      bus.ctrl_div = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) begin
            pulses++;
            if (first < 0) first = k;
         end
         if (k == 9) begin
            bus.data_operandA = 32'd5;
            bus.data_operandB = 32'd5;
            bus.ctrl_mult = 1'b1;
         end else if (k == 10) begin
            bus.ctrl_mult = 1'b0;
         end
      end
      tests_run += 3;
      if (pulses !== 1) begin
         tests_failed++;
         $display("FAIL ignore_pulse_count got %0d want 1", pulses);
      end
      if (first !== 34) begin
         tests_failed++;
         $display("FAIL ignore_div_latency got %0d want 34", first);
      end
      if (bus.data_result !== 32'hFFFFFFFD) begin
         tests_failed++;
         $display("FAIL ignore_div_result got %h want fffffffd", bus.data_result);
      end
      @(negedge clk);
      bus.data_operandA = 32'd9;
      bus.data_operandB = 32'd3;
      bus.ctrl_mult = 1'b1;
      bus.ctrl_div  = 1'b1;
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.busy) busy_cycles++;
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) pulses++;
      end
      tests_run += 3;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL both_ctrl_rdy got %0d pulses want 0", pulses);
      end
      if (busy_cycles !== 0) begin
         tests_failed++;
         $display("FAIL both_ctrl_busy got %0d busy cycles want 0", busy_cycles);
      end
      if (bus.data_result !== 32'hFFFFFFFD) begin
         tests_failed++;
         $display("FAIL both_ctrl_result got %h want fffffffd", bus.data_result);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] res, exp_res;
      logic exc, exp_exc, busy_ok, pulse_ok;
      int lat;
      int pulses = 0;
      run_op(1'b0, 32'd7, 32'hFFFFFFFD, res, exc, lat, busy_ok, pulse_ok);
      @(negedge clk);
      bus.data_operandA = 32'd3;
      bus.data_operandB = 32'd5;
      bus.ctrl_mult = 1'b1;
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      repeat (15) @(posedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
         tests_failed++;
         $display("FAIL midop_reset got res=%h exc=%b rdy=%b busy=%b want all 0",
                  bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) pulses++;
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("FAIL midop_no_rdy got %0d pulses want 0", pulses);
      end
      ref_mult(32'd3, 32'd4, exp_res, exp_exc);
      run_op(1'b0, 32'd3, 32'd4, res, exc, lat, busy_ok, pulse_ok);
      tests_run += 3;
      if (res !== exp_res) begin
         tests_failed++;
         $display("FAIL after_reset_result got %h want %h", res, exp_res);
      end
      if (exc !== exp_exc) begin
         tests_failed++;
         $display("FAIL after_reset_exception got %b want %b", exc, exp_exc);
      end
      if (lat !== 33) begin
         tests_failed++;
         $display("FAIL after_reset_latency got %0d want 33", lat);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_ignore();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
